// File: rtl/nd_pos_controller.sv
// rtl/nd_pos_controller.sv - N-axis position controller with prescaled stepping, abort and homing
module nd_pos_controller #(
    parameter int AXES     = 2,
    parameter int POS_W    = 4,
    parameter int STEP_DIV = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    input  logic [AXES*POS_W-1:0] target,
    input  logic                  motion,
    input  logic                  abort,
    input  logic                  home,
    input  logic                  mode,
    output logic [AXES*POS_W-1:0] pos,
    output logic                  busy,
    output logic                  done,
    output logic                  aborted
);

    localparam int PS_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MOVE = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]            state_q, state_d;
    logic                  m_meta_q, m_sync_q, m_prev_q;
    logic                  a_meta_q, a_sync_q;
    logic [AXES*POS_W-1:0] tgt_q, tgt_d;
    logic [AXES*POS_W-1:0] pos_q, pos_d;
    logic                  mode_q, mode_d;
    logic [PS_W-1:0]       presc_q, presc_d;
    logic                  aborted_q, aborted_d;

    logic                  motion_rise;
    logic                  tick;
    logic                  all_eq;
    logic                  seq_found;
    logic [AXES*POS_W-1:0] step_pos;

    assign motion_rise = m_sync_q & ~m_prev_q;
    assign tick        = (presc_q == PS_W'(STEP_DIV - 1));

    // Sequential mode steps only the first unsettled axis; simultaneous steps all of them.
    always_comb begin
        all_eq    = 1'b1;
        seq_found = 1'b0;
        step_pos  = pos_q;
        for (int i = 0; i < AXES; i++) begin
            if (pos_q[i*POS_W +: POS_W] != tgt_q[i*POS_W +: POS_W]) begin
                all_eq = 1'b0;
                if (!mode_q || !seq_found) begin
                    if (pos_q[i*POS_W +: POS_W] < tgt_q[i*POS_W +: POS_W])
                        step_pos[i*POS_W +: POS_W] = pos_q[i*POS_W +: POS_W] + POS_W'(1);
                    else
                        step_pos[i*POS_W +: POS_W] = pos_q[i*POS_W +: POS_W] - POS_W'(1);
                end
                seq_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        tgt_d     = tgt_q;
        pos_d     = pos_q;
        mode_d    = mode_q;
        presc_d   = presc_q;
        aborted_d = aborted_q;
        case (state_q)
            ST_IDLE: begin
                if (motion_rise) begin
                    tgt_d     = target;
                    mode_d    = mode;
                    presc_d   = '0;
                    aborted_d = 1'b0;
                    state_d   = ST_MOVE;
                end else if (home) begin
                    pos_d = '0;
                end
            end
            ST_MOVE: begin
                // Abort beats completion so an aborted move never pulses done.
                if (a_sync_q) begin
                    aborted_d = 1'b1;
                    state_d   = ST_IDLE;
                end else if (all_eq) begin
                    state_d = ST_DONE;
                end else begin
                    presc_d = tick ? '0 : presc_q + PS_W'(1);
                    if (tick)
                        pos_d = step_pos;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            m_meta_q  <= 1'b0;
            m_sync_q  <= 1'b0;
            m_prev_q  <= 1'b0;
            a_meta_q  <= 1'b0;
            a_sync_q  <= 1'b0;
            tgt_q     <= '0;
            pos_q     <= '0;
            mode_q    <= 1'b0;
            presc_q   <= '0;
            aborted_q <= 1'b0;
        end else if (ena) begin
            state_q   <= state_d;
            m_meta_q  <= motion;
            m_sync_q  <= m_meta_q;
            m_prev_q  <= m_sync_q;
            a_meta_q  <= abort;
            a_sync_q  <= a_meta_q;
            tgt_q     <= tgt_d;
            pos_q     <= pos_d;
            mode_q    <= mode_d;
            presc_q   <= presc_d;
            aborted_q <= aborted_d;
        end
    end

    assign pos     = pos_q;
    assign busy    = (state_q == ST_MOVE);
    assign done    = (state_q == ST_DONE);
    assign aborted = aborted_q;

endmodule

// File: tb/tb_nd_pos_controller.sv
// tb/tb_nd_pos_controller.sv - directed scoreboard bench for nd_pos_controller
module tb_nd_pos_controller;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] target,  target4;
    logic       motion,  motion4;
    logic       abort,   abort4;
    logic       home,    home4;
    logic       mode,    mode4;
    logic [7:0] pos,     pos4;
    logic       busy,    busy4;
    logic       done,    done4;
    logic       aborted, aborted4;

    nd_pos_controller #(.AXES(2), .POS_W(4), .STEP_DIV(1)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .target(target), .motion(motion),
        .abort(abort), .home(home), .mode(mode), .pos(pos), .busy(busy),
        .done(done), .aborted(aborted)
    );

    nd_pos_controller #(.AXES(2), .POS_W(4), .STEP_DIV(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .target(target4), .motion(motion4),
        .abort(abort4), .home(home4), .mode(mode4), .pos(pos4), .busy(busy4),
        .done(done4), .aborted(aborted4)
    );

    typedef struct {
        logic [7:0] pos;
        int         busy;
    } exp_t;

    exp_t       sb[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] cur_pos  = 8'h00;
    logic [7:0] cur_pos4 = 8'h00;
    int         k;
    bit         got_done;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected position after s step ticks from st toward tg.
    function automatic logic [7:0] model(input logic [7:0] st, input logic [7:0] tg,
                                         input logic md, input int s);
        logic [7:0] r;
        int rem, a, b, dlt, mv;
        r   = st;
        rem = s;
        for (int i = 0; i < 2; i++) begin
            a   = int'(st[i*4 +: 4]);
            b   = int'(tg[i*4 +: 4]);
            dlt = (a > b) ? a - b : b - a;
            if (md) begin
                mv  = (rem < dlt) ? rem : dlt;
                rem = rem - mv;
            end else begin
                mv = (s < dlt) ? s : dlt;
            end
            r[i*4 +: 4] = (b >= a) ? 4'(a + mv) : 4'(a - mv);
        end
        return r;
    endfunction

    // opt: 1 = pulse home during MOVE, 2 = drop ena mid-move, 3 = change target mid-move
    task automatic run_move(input bit sel, input logic [7:0] tg, input logic md, input int d,
                            input int exp_busy, input int opt, input string tag);
        logic [7:0] st;
        logic [7:0] o_pos;
        exp_t       e;
        int         kk, traj_err;
        bit         seen;
        st = sel ? cur_pos4 : cur_pos;
        sb.push_back('{pos: tg, busy: exp_busy});
        @(negedge clk);
        if (sel) begin
            target4 = tg;
            motion4 = 1'b1;
        end else begin
            target = tg;
            mode   = md;
            motion = 1'b1;
        end
        kk = 0; traj_err = 0; seen = 1'b0;
        for (int c = 0; c < 400 && !seen; c++) begin
            @(negedge clk);
            o_pos = sel ? pos4 : pos;
            if (sel ? done4 : done) begin
                seen = 1'b1;
            end else if (sel ? busy4 : busy) begin
                kk++;
                if (o_pos !== model(st, tg, md, (kk - 1) / d)) traj_err++;
                if (opt == 1 && kk == 1) home = 1'b1;
                if (opt == 3 && kk == 1) target = ~tg;
                if (opt == 2 && kk == 2) begin
                    ena = 1'b0;
                    repeat (5) begin
                        @(negedge clk);
                        if (pos !== model(st, tg, md, 1)) traj_err++;
                    end
                    ena = 1'b1;
                end
            end
        end
        home = 1'b0; motion = 1'b0; motion4 = 1'b0;
        chk({tag, "_done_seen"}, 32'(seen), 32'd1);
        e = sb.pop_front();
        chk({tag, "_busy_cycles"}, 32'(kk), 32'(e.busy));
        chk({tag, "_final_pos"}, 32'(sel ? pos4 : pos), 32'(e.pos));
        chk({tag, "_trajectory_errs"}, 32'(traj_err), 32'd0);
        chk({tag, "_aborted"}, 32'(sel ? aborted4 : aborted), 32'd0);
        @(negedge clk);
        chk({tag, "_done_single"}, 32'(sel ? done4 : done), 32'd0);
        if (sel) cur_pos4 = tg; else cur_pos = tg;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b1;
        target = '0; motion = 0; abort = 0; home = 0; mode = 0;
        target4 = '0; motion4 = 0; abort4 = 0; home4 = 0; mode4 = 0;
        repeat (2) @(negedge clk);
        chk("reset_pos", 32'(pos), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_aborted", 32'(aborted), 32'd0);
        chk("reset_pos4", 32'(pos4), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_move(1'b0, 8'h53, 1'b0, 1, 6, 0, "simul_3_5");
        @(negedge clk); home = 1'b1;
        @(negedge clk); home = 1'b0;
        chk("home_idle", 32'(pos), 32'd0);
        cur_pos = 8'h00;
        repeat (2) @(negedge clk);
        run_move(1'b0, 8'h53, 1'b1, 1, 9, 0, "seq_3_5");

        run_move(1'b1, 8'h27, 1'b0, 4, 29, 0, "div4_to_7_2");
        run_move(1'b1, 8'h22, 1'b0, 4, 21, 0, "div4_7_to_2");

        run_move(1'b0, 8'h53, 1'b0, 1, 1, 0, "zero_move");
        run_move(1'b0, 8'h11, 1'b0, 1, 5, 1, "home_in_move");
        run_move(1'b0, 8'h66, 1'b0, 1, 6, 2, "ena_freeze");
        run_move(1'b0, 8'h00, 1'b1, 1, 13, 3, "tgt_change");

        // Abort raised at the 4th busy sample: two sync stages let pos reach (5,5).
        @(negedge clk);
        target = 8'h99; mode = 1'b0; motion = 1'b1;
        k = 0; got_done = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (done) got_done = 1'b1;
            if (busy) begin
                k++;
                if (k == 4) begin
                    chk("abort_pre_pos", 32'(pos), 32'h33);
                    abort = 1'b1;
                end
            end else if (k > 0) begin
                break;
            end
        end
        chk("abort_busy_cycles", 32'(k), 32'd6);
        chk("abort_pos", 32'(pos), 32'h55);
        chk("abort_flag", 32'(aborted), 32'd1);
        chk("abort_no_done", 32'(got_done), 32'd0);
        abort = 1'b0; motion = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_sticky", 32'(aborted), 32'd1);
        chk("abort_pos_hold", 32'(pos), 32'h55);
        cur_pos = 8'h55;
        run_move(1'b0, 8'h99, 1'b0, 1, 5, 0, "after_abort");

        @(negedge clk);
        target = 8'hff; motion = 1'b1; k = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (busy) k++;
            if (k == 3) break;
        end
        chk("rst_mid_busy_seen", 32'(k), 32'd3);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_pos", 32'(pos), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_done", 32'(done), 32'd0);
        chk("rst_mid_aborted", 32'(aborted), 32'd0);
        motion = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("post_rst_idle", 32'(busy), 32'd0);
        chk("post_rst_pos", 32'(pos), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
